// File: rtl/fixed_attention_score_scale_mask_pkg.sv
`default_nettype none
//==============================================================================
// Module      : fixed_attention_score_scale_mask_pkg
// Description : Shared sizing helpers, default-configuration constants and the
//               round-half-up / saturate helper of the attention-score
//               scale/mask stage.
// Revision    : 1.0 - initial release
//==============================================================================
package fixed_attention_score_scale_mask_pkg;

   // Number of beats along one matrix dimension.
   function automatic int blocks_per_dim(input int size, input int par);
      return size / par;
   endfunction

   // Signed logit times unsigned scale, plus one guard bit.
   function automatic int product_width(input int in_w, input int scale_w);
      return in_w + scale_w + 1;
   endfunction

   // Most negative code of a signed out_w-bit output.
   function automatic logic signed [63:0] mask_code(input int out_w);
      return -(64'sd1 <<< (out_w - 1));
   endfunction

   // Default configuration: 32x32 score matrix, 4x4 elements per beat,
   // 16-bit logits and an 8-bit scale constant.
   localparam int          c_D0            = blocks_per_dim(32, 4);
   localparam int          c_D1            = blocks_per_dim(32, 4);
   localparam int          c_PRODUCT_WIDTH = product_width(16, 8);
   localparam logic [15:0] c_MASK_CODE     = 16'h8000;

   // Drop 'shift' fractional bits with round-half-up (add half an LSB, then
   // floor via arithmetic shift), then clamp into the signed out_w-bit range.
   // A non-positive shift means the output keeps more fraction than the
   // product, so the value is shifted left instead.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                    input int                 shift,
                                                    input int                 out_w);
      logic signed [63:0] res;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      if (shift > 0) begin
         res = (v + (64'sd1 <<< (shift - 1))) >>> shift;
      end else begin
         res = v <<< (-shift);
      end
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (res > hi) begin
         res = hi;
      end else if (res < lo) begin
         res = lo;
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_attention_score_scale_mask_if.sv
`default_nettype none
//==============================================================================
// Module      : fixed_attention_score_scale_mask_if
// Description : Valid/ready block stream carrying COUNT signed elements of
//               WIDTH bits; element i = y*PARALLELISM_DIM_0 + x.
// Revision    : 1.0 - initial release
//==============================================================================
interface fixed_attention_score_scale_mask_if #(
   parameter int WIDTH = 16,
   parameter int COUNT = 16
) ();
   logic [COUNT-1:0][WIDTH-1:0] data;
   logic                        valid;
   logic                        ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/fixed_attention_score_scale_mask_pos_counter.sv
`default_nettype none
//==============================================================================
// Module      : attention_block_position_counter
// Description : Tracks the (row block, column block) position of each accepted
//               beat of a row-major block stream, flags the first and last
//               beat of a matrix and compares every element's global column
//               against its global row (col > row, i.e. above the diagonal).
// Revision    : 1.0 - initial release
//==============================================================================
module attention_block_position_counter #(
   parameter int D0   = 4,
   parameter int D1   = 4,
   parameter int PAR0 = 2,
   parameter int PAR1 = 2
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   input  wire logic                   advance_i,
   output logic                        first_o,
   output logic                        last_o,
   output logic [PAR0*PAR1-1:0]        above_diag_o
);
   localparam int c_CW = (D0 > 1) ? $clog2(D0) : 1;
   localparam int c_RW = (D1 > 1) ? $clog2(D1) : 1;

   logic [c_CW-1:0] col_blk_q;
   logic [c_CW-1:0] col_blk_d;
   logic [c_RW-1:0] row_blk_q;
   logic [c_RW-1:0] row_blk_d;

   // Column block runs fastest; its wrap steps the row block, which wraps
   // back to (0,0) at the end of the matrix.
   always_comb begin
      col_blk_d = col_blk_q;
      row_blk_d = row_blk_q;
      if (advance_i) begin
         if (col_blk_q == c_CW'(D0 - 1)) begin
            col_blk_d = '0;
            if (row_blk_q == c_RW'(D1 - 1)) begin
               row_blk_d = '0;
            end else begin
               row_blk_d = row_blk_q + c_RW'(1);
            end
         end else begin
            col_blk_d = col_blk_q + c_CW'(1);
         end
      end
   end

   // Position registers; cleared so the next accepted beat after reset is (0,0).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_blk_q <= '0;
         row_blk_q <= '0;
      end else begin
         col_blk_q <= col_blk_d;
         row_blk_q <= row_blk_d;
      end
   end

   assign first_o = (col_blk_q == '0) && (row_blk_q == '0);
   assign last_o  = (col_blk_q == c_CW'(D0 - 1)) && (row_blk_q == c_RW'(D1 - 1));

   for (genvar y = 0; y < PAR1; y++) begin : g_row
      for (genvar x = 0; x < PAR0; x++) begin : g_col
         logic [31:0] w_col;
         logic [31:0] w_row;
         assign w_col = 32'(col_blk_q) * 32'(PAR0) + 32'(x);
         assign w_row = 32'(row_blk_q) * 32'(PAR1) + 32'(y);
         assign above_diag_o[y*PAR0 + x] = (w_col > w_row);
      end
   end

endmodule
`default_nettype wire

// File: rtl/fixed_attention_score_scale_mask.sv
`default_nettype none
//==============================================================================
// Module      : fixed_attention_score_scale_mask
// Description : Scales every attention logit by 1/sqrt(head_dim), rounds and
//               saturates into the output precision, and in causal mode
//               replaces logits above the diagonal with the most negative code.
//               Two-stage pipeline under a single global enable.
// Revision    : 1.0 - initial release
//==============================================================================
module fixed_attention_score_scale_mask
   import fixed_attention_score_scale_mask_pkg::*;
#(
   parameter int DATA_IN_0_PRECISION_0  = 16,
   parameter int DATA_IN_0_PRECISION_1  = 3,
   parameter int DATA_OUT_0_PRECISION_0 = 16,
   parameter int DATA_OUT_0_PRECISION_1 = 3,
   parameter int TENSOR_SIZE_DIM_0      = 32,
   parameter int TENSOR_SIZE_DIM_1      = 32,
   parameter int PARALLELISM_DIM_0      = 4,
   parameter int PARALLELISM_DIM_1      = 4,
   parameter int SCALE_WIDTH            = 8,
   parameter int SCALE_FRAC_WIDTH       = 8,
   parameter int SCALE_MANTISSA         = 16
) (
   input  wire logic                          clk,
   input  wire logic                          rst,
   input  wire logic                          causal_en,
   fixed_attention_score_scale_mask_if.slave  data_in_0,
   fixed_attention_score_scale_mask_if.master data_out_0,
   output logic                               matrix_done
);
   localparam int c_P        = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
   localparam int c_COL_BLKS = blocks_per_dim(TENSOR_SIZE_DIM_0, PARALLELISM_DIM_0);
   localparam int c_ROW_BLKS = blocks_per_dim(TENSOR_SIZE_DIM_1, PARALLELISM_DIM_1);
   localparam int c_PW       = product_width(DATA_IN_0_PRECISION_0, SCALE_WIDTH);
   localparam int c_SHIFT    = DATA_IN_0_PRECISION_1 + SCALE_FRAC_WIDTH - DATA_OUT_0_PRECISION_1;
   localparam int c_OW       = DATA_OUT_0_PRECISION_0;

   // Scale is unsigned: a zero above its MSB keeps it positive in signed math.
   localparam logic signed [c_PW-1:0]   c_SCALE = c_PW'({1'b0, SCALE_MANTISSA[SCALE_WIDTH-1:0]});
   localparam logic        [c_OW-1:0]   c_MASK  = c_OW'(mask_code(c_OW));

   logic                    w_en;
   logic                    w_in_fire;
   logic                    w_first;
   logic                    w_last;
   logic                    w_mode;
   logic [c_P-1:0]          w_above;
   logic signed [c_PW-1:0]  w_prod  [c_P];
   logic [c_OW-1:0]         w_round [c_P];

   logic                    causal_q;
   logic                    s1_valid_q;
   logic                    s1_last_q;
   logic [c_P-1:0]          s1_mask_q;
   logic signed [c_PW-1:0]  s1_prod_q [c_P];
   logic                    s2_valid_q;
   logic                    s2_last_q;
   logic [c_P-1:0][c_OW-1:0] s2_data_q;
   logic                    done_q;

   // Whole pipeline advances unless a finished output is waiting on a stall.
   assign w_en            = !s2_valid_q || data_out_0.ready;
   assign data_in_0.ready = w_en && rst;
   assign w_in_fire       = data_in_0.valid && data_in_0.ready;

   attention_block_position_counter #(
      .D0   (c_COL_BLKS),
      .D1   (c_ROW_BLKS),
      .PAR0 (PARALLELISM_DIM_0),
      .PAR1 (PARALLELISM_DIM_1)
   ) u_pos (
      .clk          (clk),
      .rst          (rst),
      .advance_i    (w_in_fire),
      .first_o      (w_first),
      .last_o       (w_last),
      .above_diag_o (w_above)
   );

   // The first beat of a matrix uses the causal_en it is sampling, not the
   // previous matrix's mode.
   assign w_mode = w_first ? causal_en : causal_q;

   for (genvar i = 0; i < c_P; i++) begin : g_elem
      assign w_prod[i]  = c_PW'($signed(data_in_0.data[i])) * c_SCALE;
      assign w_round[i] = c_OW'(round_sat(64'(s1_prod_q[i]), c_SHIFT, c_OW));
   end

   // Causal mode is latched on the (0,0) handshake and held for the matrix.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         causal_q <= 1'b0;
      end else if (w_in_fire && w_first) begin
         causal_q <= causal_en;
      end
   end

   // Stage 1: full-precision product, per-element mask and last-beat flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_mask_q  <= '0;
         for (int i = 0; i < c_P; i++) begin
            s1_prod_q[i] <= '0;
         end
      end else if (w_en) begin
         s1_valid_q <= w_in_fire;
         s1_last_q  <= w_in_fire && w_last;
         s1_mask_q  <= w_mode ? w_above : '0;
         for (int i = 0; i < c_P; i++) begin
            s1_prod_q[i] <= w_prod[i];
         end
      end
   end

   // Stage 2: rounded/saturated result, or the mask code above the diagonal.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_data_q  <= '0;
      end else if (w_en) begin
         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_valid_q && s1_last_q;
         for (int i = 0; i < c_P; i++) begin
            s2_data_q[i] <= s1_mask_q[i] ? c_MASK : w_round[i];
         end
      end
   end

   // One-cycle pulse after the last beat of a matrix leaves the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= s2_valid_q && data_out_0.ready && s2_last_q;
      end
   end

   assign data_out_0.valid = s2_valid_q;
   assign data_out_0.data  = s2_data_q;
   assign matrix_done      = done_q;

endmodule
`default_nettype wire
